// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable UART receiver.
//
// Receives LSB-first asynchronous frames of the form
//   start(0) | DATA_BITS data | optional parity | STOP_BITS stop(1)
// Every bit is decided by a 3-sample majority vote over the synchronised line.
// The receiver reports parity errors, framing errors and line breaks. Every
// frame is delivered, errored or not, and the consumer decides what to keep.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit period (8..65535)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports
//   i_Clock       system clock
//   i_Reset       asynchronous, active-high reset
//   i_Rx_Serial   asynchronous serial line, idles high
//   o_Rx_DV       one-cycle pulse: frame complete, data and flags valid
//   o_Rx_Byte     received data, held until the next o_Rx_DV
//   o_Parity_Err  parity mismatch in the last frame (held)
//   o_Frame_Err   a stop bit was sampled low in the last frame (held)
//   o_Break       the last frame was a line break (held)
//   o_Rx_Busy     high whenever the receiver is not idle
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Rx_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  // Decision points: mid-bit for the start bit, end of period for the rest
  // (the start decision already placed the count at mid-bit).
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_CLEANUP   = 3'd5,
    S_WAIT_IDLE = 3'd6
  } state_t;

  state_t                 state;
  logic                   sync_p0;
  logic                   sync_p1;
  logic [2:0]             hist;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_acc;
  logic                   par_bit;
  logic                   perr;
  logic                   ferr;
  logic                   maj;
  logic                   brk_cond;

  // Majority of three samples: a single-cycle glitch cannot flip a decision.
  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction

  // Expected parity bit given the XOR of the received data bits.
  function automatic logic par_expected(input logic acc);
    return (PARITY == 1) ? ~acc : acc;
  endfunction

  assign maj       = maj3(hist);
  assign o_Rx_Busy = (state != S_IDLE);

  // A break is an all-zero frame (parity bit zero too, when present) whose
  // stop bit also read low.
  assign brk_cond  = (shift == '0) && ((PARITY == 0) || !par_bit) && ferr;

  // Stage p0/p1: two-flop synchroniser, then a 3-deep sample history.
  // All ones at reset so an idle line never looks like a start bit.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      hist    <= 3'b111;
    end else begin
      sync_p0 <= i_Rx_Serial;
      sync_p1 <= sync_p0;
      hist    <= {hist[1:0], sync_p1};
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      stop_idx     <= 1'b0;
      shift        <= '0;
      par_acc      <= 1'b0;
      par_bit      <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_Rx_DV <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          idx      <= '0;
          stop_idx <= 1'b0;
          if (!sync_p1) begin
            state <= S_START;
          end
        end

        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!maj) begin
              state   <= S_DATA;
              par_acc <= 1'b0;
              par_bit <= 1'b0;
              perr    <= 1'b0;
              ferr    <= 1'b0;
            end else begin
              // Line was back high by mid-bit: treat as a glitch.
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= maj;
            par_acc    <= par_acc ^ maj;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= maj;
            perr    <= (maj != par_expected(par_acc));
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          // The last stop bit is decided at its own decision point rather
          // than at its end, leaving slack for a back-to-back start bit.
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!maj) begin
              ferr <= 1'b1;
            end
            if (stop_idx == STOP_LAST) begin
              state <= S_CLEANUP;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_CLEANUP: begin
          o_Rx_DV      <= 1'b1;
          o_Rx_Byte    <= shift;
          o_Parity_Err <= perr;
          o_Frame_Err  <= ferr;
          o_Break      <= brk_cond;
          // After a framing error the line may still be low (break); wait
          // for it to return high so it is not taken as a new start bit.
          state        <= ferr ? S_WAIT_IDLE : S_IDLE;
        end

        S_WAIT_IDLE: begin
          if (sync_p1) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Data width, parity mode and stop-bit count are configurable. Each bit decision is a 3-sample majority vote, and the block reports parity error, framing error and line break. It sits between the pad-side serial input and the byte-stream consumer (FIFO or register interface).

Parameters:
CLKS_PER_BIT, 87, clocks per bit period; legal range 8..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9; LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
i_Clock  in  1  system clock.
i_Reset  in  1  reset, asynchronous and active-high.
i_Rx_Serial  in  1  asynchronous serial line; idles high.
o_Rx_DV  out  1  one-cycle pulse; frame complete, data and flags valid.
o_Rx_Byte  out  DATA_BITS  received data; held until next o_Rx_DV.
o_Parity_Err  out  1  parity mismatch for the last frame; held until next o_Rx_DV.
o_Frame_Err  out  1  a stop bit sampled low in the last frame; held until next o_Rx_DV.
o_Break  out  1  last frame was a break; held until next o_Rx_DV.
o_Rx_Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, i_Reset=1):
  - state=IDLE; counters cleared.
  - 2-flop synchroniser and 3-bit sample history set to all-ones.
  - Every output 0. Reset mid-frame discards the partial frame; no o_Rx_DV is issued.
- Input path: 2-flop synchroniser; the 3-bit history shifts in the synchronised bit every cycle.
- Decision value = majority of the 3 history bits, taken on the decision cycle.
- Bit counter width is clog2(CLKS_PER_BIT).
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_IDLE.
- IDLE: count=0, bit index=0. Synchronised line = 0 -> START.
- START:
  - Count 0..(CLKS_PER_BIT-1)/2; decide when count reaches (CLKS_PER_BIT-1)/2.
  - Majority 0 -> DATA, count=0. Majority 1 -> IDLE (glitch rejected, no DV).
- DATA:
  - Decide each bit at count=CLKS_PER_BIT-1, then count=0.
  - Store the bit at the bit index, LSB first; also accumulate XOR of the data bits.
  - After bit DATA_BITS-1: go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - One bit period, same decision point.
  - Expected bit: even mode = XOR of data; odd mode = ~XOR of data.
  - Mismatch sets the internal parity error.
- STOP:
  - STOP_BITS periods, each decided at count=CLKS_PER_BIT-1.
  - Any stop decision of 0 sets the internal frame error.
  - The decision also resolves within a 1-stop frame so that back-to-back frames are not lost.
  - Then go to CLEANUP.
- CLEANUP (one cycle):
  - o_Rx_DV=1.
  - o_Rx_Byte and all three flags load their internal values.
  - Break condition (all data bits 0, parity bit 0 or absent, frame error set): o_Break=1, and o_Frame_Err=1.
  - Next state: WAIT_IDLE if a frame error occurred, else IDLE.
- WAIT_IDLE: stay until synchronised line = 1, then IDLE. This prevents a held-low line from retriggering START.
- Latency: o_Rx_DV rises 1 cycle after the last stop-bit decision cycle. From the line falling edge the nominal latency is 2 (sync) + (CLKS_PER_BIT-1)/2 + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1 cycles, where P = 1 if PARITY!=0 else 0.
- Every frame is delivered, including errored frames; the consumer decides whether to drop them.
- Sticky-flag rule: flags change only on o_Rx_DV cycles.
- Unused states decode to IDLE.

Test Plan (CLKS_PER_BIT=16 unless noted):
- 8N1, send 0xA5 then 0x3C back-to-back, 1 stop bit each -> two o_Rx_DV pulses with o_Rx_Byte=0xA5 then 0x3C; all flags 0; pulses spaced exactly 160 cycles.
- PARITY=2, DATA_BITS=8:
  - Send 0xA5 with parity bit 0 -> byte 0xA5, o_Parity_Err=0.
  - Resend with parity bit 1 -> o_Parity_Err=1, byte still 0xA5.
  - PARITY=1: parity bit 1 accepted.
- Drive i_Rx_Serial low for 3 cycles from idle -> START aborts, no o_Rx_DV, o_Rx_Busy returns to 0; then a valid 0x55 is received correctly.
- Send 0x81 with the stop bit driven low -> o_Rx_DV, byte 0x81, o_Frame_Err=1, o_Break=0; line then held high -> IDLE.
- Hold line low for 20 bit periods -> exactly one o_Rx_DV with byte 0x00, o_Break=1, o_Frame_Err=1; o_Rx_Busy stays 1 until line returns high; next 0x42 is received cleanly.
- Combined stimulus:
  - DATA_BITS=7, STOP_BITS=2, frame 0x5A with a 1-cycle 0 glitch at the centre of data bit 3 -> byte 0x5A (majority filters it).
  - Second stop bit low -> o_Frame_Err=1.
  - Assert i_Reset mid-DATA -> outputs 0 immediately, no DV.
